counter_bank: RTL and testbench

Parametrised multi-channel counter bank; the next generation of the board counter samples. N independent WIDTH-bit channels share one programmable prescaler and provide per-channel host controls: reset, load, disable, auto-count, up/down pulses, compare match, and wrap/saturate limit reporting. A coherent snapshot register lets the host read all channels from one instant. It sits between the host endpoint wiring (wire-ins and trigger-ins on the control side, wire-outs and trigger-outs on the status side) and the board logic, all in one clock domain.

---
 rtl/counter_bank_pkg.sv | 22 ++
 rtl/counter_bank_channel.sv | 115 +++++++++++
 rtl/counter_bank.sv | 99 +++++++++
 tb/tb_counter_bank.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_bank_pkg.sv
// Purpose: shared constants, step encoding and channel-slice helper for counter_bank.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package counter_bank_pkg;

    localparam int CB_N_DEF     = 4;
    localparam int CB_WIDTH_DEF = 16;
    localparam int CB_DIV_W_DEF = 24;

    // Resolved single step a channel takes in one cycle, after priority.
    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DOWN = 2'd2
    } step_e;

    // Bit offset of channel idx inside a flattened N*width bus.
    function automatic int ch_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/counter_bank_channel.sv
// Purpose: one counter channel with reset/load/step priority, match edge detect and limit detect.
// Latency: count and limit_trig 1 cycle after control; match_trig 1 cycle after count equals compare.
// Backpressure: none; every control is acted on in the cycle it is sampled.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   tick_i                shared prescaler pulse
//   reset_i, load_i       level controls: clear / load count
//   disable_i             blocks up, down and auto steps
//   auto_i, up_i, down_i  step sources
//   load_value_i          value taken on load
//   compare_i             match value
//   count_o               live count
//   match_trig_o          pulse on entry into count == compare
//   limit_trig_o          pulse on a step past all-ones or below zero
module counter_bank_channel
    import counter_bank_pkg::*;
#(
    parameter int WIDTH    = CB_WIDTH_DEF,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             tick_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic             disable_i,
    input  logic             auto_i,
    input  logic             up_i,
    input  logic             down_i,
    input  logic [WIDTH-1:0] load_value_i,
    input  logic [WIDTH-1:0] compare_i,
    output logic [WIDTH-1:0] count_o,
    output logic             match_trig_o,
    output logic             limit_trig_o
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             limit_q, limit_d;
    logic             match_lvl_q;
    logic             match_trig_q;
    logic             eq;
    step_e            step;

    // Up beats down, manual beats auto; at most one step per cycle.
    always_comb begin
        step = STEP_NONE;
        if (!disable_i) begin
            if (up_i) begin
                step = STEP_UP;
            end else if (down_i) begin
                step = STEP_DOWN;
            end else if (auto_i && tick_i) begin
                step = STEP_UP;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        limit_d = 1'b0;
        if (reset_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_value_i;
        end else begin
            case (step)
                STEP_UP: begin
                    if (count_q == CNT_MAX) begin
                        limit_d = 1'b1;
                        if (SATURATE) count_d = CNT_MAX;
                        else          count_d = '0;
                    end else begin
                        count_d = count_q + CNT_ONE;
                    end
                end
                STEP_DOWN: begin
                    if (count_q == '0) begin
                        limit_d = 1'b1;
                        if (SATURATE) count_d = '0;
                        else          count_d = CNT_MAX;
                    end else begin
                        count_d = count_q - CNT_ONE;
                    end
                end
                default: count_d = count_q;
            endcase
        end
    end

    assign eq = (count_q == compare_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q      <= '0;
            limit_q      <= 1'b0;
            match_lvl_q  <= 1'b0;
            match_trig_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            limit_q      <= limit_d;
            // Rising edge of equality only; re-arms once count leaves compare.
            match_lvl_q  <= eq;
            match_trig_q <= eq & ~match_lvl_q;
        end
    end

    assign count_o      = count_q;
    assign match_trig_o = match_trig_q;
    assign limit_trig_o = limit_q;

endmodule

// File: rtl/counter_bank.sv
// Purpose: N-channel counter bank with shared programmable prescaler and coherent snapshot.
// Latency: control to count 1 cycle; capture to snapshot 1 cycle; first tick 2nd cycle after reset.
// Backpressure: none; pulses and levels are consumed in the cycle they are sampled.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   div_reload                 prescaler period minus one (applied at next reload)
//   ch_reset/ch_load/ch_disable/ch_auto/up/down   per-channel controls (N bits each)
//   load_value                 shared load value
//   compare                    per-channel match values, channel i at [i*WIDTH +: WIDTH]
//   capture                    snapshot strobe
//   tick, count, snapshot, match_trig, limit_trig   status outputs
module counter_bank
    import counter_bank_pkg::*;
#(
    parameter int N        = CB_N_DEF,
    parameter int WIDTH    = CB_WIDTH_DEF,
    parameter int DIV_W    = CB_DIV_W_DEF,
    parameter int SATURATE = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DIV_W-1:0]   div_reload,
    input  logic [N-1:0]       ch_reset,
    input  logic [N-1:0]       ch_load,
    input  logic [WIDTH-1:0]   load_value,
    input  logic [N-1:0]       ch_disable,
    input  logic [N-1:0]       ch_auto,
    input  logic [N-1:0]       up,
    input  logic [N-1:0]       down,
    input  logic [N*WIDTH-1:0] compare,
    input  logic               capture,
    output logic               tick,
    output logic [N*WIDTH-1:0] count,
    output logic [N*WIDTH-1:0] snapshot,
    output logic [N-1:0]       match_trig,
    output logic [N-1:0]       limit_trig
);

    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

    logic [DIV_W-1:0]   presc_q, presc_d;
    logic               tick_q, tick_d;
    logic [N*WIDTH-1:0] snap_q, snap_d;

    // Down-counter starting at 0, so the first reload (and tick) happens
    // on the first edge after reset release.
    always_comb begin
        if (presc_q == '0) begin
            presc_d = div_reload;
            tick_d  = 1'b1;
        end else begin
            presc_d = presc_q - DIV_ONE;
            tick_d  = 1'b0;
        end
    end

    // Snapshot takes the pre-update counts of the capture cycle.
    assign snap_d = capture ? count : snap_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            snap_q  <= '0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
            snap_q  <= snap_d;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_ch
        localparam int LO = ch_lo(g, WIDTH);
        counter_bank_channel #(
            .WIDTH    (WIDTH),
            .SATURATE (SATURATE != 0)
        ) u_ch (
            .clk_i        (clk),
            .rst_i        (reset),
            .tick_i       (tick_q),
            .reset_i      (ch_reset[g]),
            .load_i       (ch_load[g]),
            .disable_i    (ch_disable[g]),
            .auto_i       (ch_auto[g]),
            .up_i         (up[g]),
            .down_i       (down[g]),
            .load_value_i (load_value),
            .compare_i    (compare[LO +: WIDTH]),
            .count_o      (count[LO +: WIDTH]),
            .match_trig_o (match_trig[g]),
            .limit_trig_o (limit_trig[g])
        );
    end

    assign tick     = tick_q;
    assign snapshot = snap_q;

endmodule

// File: tb/tb_counter_bank.sv
module tb_counter_bank;

    localparam int N     = 4;
    localparam int WIDTH = 16;
    localparam int DIV_W = 24;
    localparam longint MAXV = (longint'(1) << WIDTH) - 1;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [DIV_W-1:0]   div_reload = '0;
    logic [N-1:0]       ch_reset = '0;
    logic [N-1:0]       ch_load = '0;
    logic [WIDTH-1:0]   load_value = '0;
    logic [N-1:0]       ch_disable = '0;
    logic [N-1:0]       ch_auto = '0;
    logic [N-1:0]       up = '0;
    logic [N-1:0]       down = '0;
    logic [N*WIDTH-1:0] compare = '0;
    logic               capture = 1'b0;

    logic               tick_s0, tick_s1;
    logic [N*WIDTH-1:0] count_s0, count_s1, snap_s0, snap_s1;
    logic [N-1:0]       mt_s0, mt_s1, lt_s0, lt_s1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    counter_bank #(.N(N), .WIDTH(WIDTH), .DIV_W(DIV_W), .SATURATE(0)) u_dut_wrap (
        .clk(clk), .reset(reset), .div_reload(div_reload), .ch_reset(ch_reset),
        .ch_load(ch_load), .load_value(load_value), .ch_disable(ch_disable),
        .ch_auto(ch_auto), .up(up), .down(down), .compare(compare), .capture(capture),
        .tick(tick_s0), .count(count_s0), .snapshot(snap_s0),
        .match_trig(mt_s0), .limit_trig(lt_s0)
    );

    counter_bank #(.N(N), .WIDTH(WIDTH), .DIV_W(DIV_W), .SATURATE(1)) u_dut_sat (
        .clk(clk), .reset(reset), .div_reload(div_reload), .ch_reset(ch_reset),
        .ch_load(ch_load), .load_value(load_value), .ch_disable(ch_disable),
        .ch_auto(ch_auto), .up(up), .down(down), .compare(compare), .capture(capture),
        .tick(tick_s1), .count(count_s1), .snapshot(snap_s1),
        .match_trig(mt_s1), .limit_trig(lt_s1)
    );

    // Reference model: index 0 = wrapping bank, index 1 = saturating bank.
    longint m_cnt [2][N];
    longint m_snap[2][N];
    bit     m_lim [2][N];
    bit     m_mt  [2][N];
    bit     m_eq  [2][N];
    longint m_presc;
    bit     m_tick;

    function automatic void model_reset();
        m_presc = 0;
        m_tick  = 0;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < N; i++) begin
                m_cnt[s][i] = 0; m_snap[s][i] = 0;
                m_lim[s][i] = 0; m_mt[s][i] = 0; m_eq[s][i] = 0;
            end
    endfunction

    // Applies one rising edge using the inputs currently driven.
    function automatic void model_edge();
        bit     old_tick;
        longint cmp, nxt;
        int     delta;
        if (reset) begin
            model_reset();
            return;
        end
        old_tick = m_tick;
        if (m_presc == 0) begin
            m_presc = longint'(div_reload);
            m_tick  = 1;
        end else begin
            m_presc = m_presc - 1;
            m_tick  = 0;
        end
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < N; i++) begin
                cmp = longint'(compare[i*WIDTH +: WIDTH]);
                m_mt[s][i] = (m_cnt[s][i] == cmp) && !m_eq[s][i];
                m_eq[s][i] = (m_cnt[s][i] == cmp);
                if (capture) m_snap[s][i] = m_cnt[s][i];
                m_lim[s][i] = 0;
                if (ch_reset[i]) begin
                    m_cnt[s][i] = 0;
                end else if (ch_load[i]) begin
                    m_cnt[s][i] = longint'(load_value);
                end else if (!ch_disable[i]) begin
                    delta = up[i] ? 1 : (down[i] ? -1 : ((ch_auto[i] && old_tick) ? 1 : 0));
                    if (delta != 0) begin
                        nxt = m_cnt[s][i] + delta;
                        if (nxt > MAXV || nxt < 0) begin
                            m_lim[s][i] = 1;
                            if (s == 0) m_cnt[s][i] = nxt & MAXV;
                        end else begin
                            m_cnt[s][i] = nxt;
                        end
                    end
                end
            end
        end
    endfunction

    function automatic logic [N*WIDTH-1:0] exp_cnt(input int s);
        logic [N*WIDTH-1:0] v;
        for (int i = 0; i < N; i++) v[i*WIDTH +: WIDTH] = WIDTH'(m_cnt[s][i]);
        return v;
    endfunction

    function automatic logic [N*WIDTH-1:0] exp_snap(input int s);
        logic [N*WIDTH-1:0] v;
        for (int i = 0; i < N; i++) v[i*WIDTH +: WIDTH] = WIDTH'(m_snap[s][i]);
        return v;
    endfunction

    function automatic logic [N-1:0] exp_mt(input int s);
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_mt[s][i];
        return v;
    endfunction

    function automatic logic [N-1:0] exp_lt(input int s);
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_lim[s][i];
        return v;
    endfunction

    // One clock: model follows the edge, outputs settle 1ns later.
    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        div_reload = DIV_W'(3);
        ch_auto = 4'b0001;
        repeat (5) cyc();
        checks++;
        if ({count_s0, count_s1} !== '0) begin
            errors++; $display("FAIL reset_count got %h %h want 0", count_s0, count_s1);
        end
        checks++;
        if ({snap_s0, snap_s1} !== '0) begin
            errors++; $display("FAIL reset_snapshot got %h %h want 0", snap_s0, snap_s1);
        end
        checks++;
        if ({tick_s0, tick_s1, mt_s0, mt_s1, lt_s0, lt_s1} !== '0) begin
            errors++; $display("FAIL reset_pulses tick %b %b mt %b %b lt %b %b want 0",
                               tick_s0, tick_s1, mt_s0, mt_s1, lt_s0, lt_s1);
        end
    endtask

    task automatic test_prescaler();
        logic exp_t;
        reset = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            cyc();
            exp_t = ((k % 4) == 1);
            checks++;
            if (tick_s0 !== exp_t || tick_s1 !== exp_t) begin
                errors++; $display("FAIL prescaler_tick cycle %0d got %b %b want %b", k, tick_s0, tick_s1, exp_t);
            end
        end
        checks++;
        if (count_s0[15:0] !== 16'd5 || count_s1[15:0] !== 16'd5) begin
            errors++; $display("FAIL auto_count ch0 got %h %h want 0005", count_s0[15:0], count_s1[15:0]);
        end
        checks++;
        if (count_s0[63:16] !== '0 || count_s1[63:16] !== '0) begin
            errors++; $display("FAIL idle_channels got %h %h want 0", count_s0[63:16], count_s1[63:16]);
        end
    endtask

    task automatic test_wrap_saturate();
        logic [15:0] e0 [3] = '{16'hFFFF, 16'h0000, 16'h0001};
        logic [15:0] e1 [3] = '{16'hFFFF, 16'hFFFF, 16'hFFFF};
        logic        l0 [3] = '{1'b0, 1'b1, 1'b0};
        logic        l1 [3] = '{1'b0, 1'b1, 1'b1};
        int n0 = 0, n1 = 0;
        load_value = 16'hFFFE;
        ch_load = 4'b0010;
        cyc();
        ch_load = '0;
        checks++;
        if (count_s0[31:16] !== 16'hFFFE || count_s1[31:16] !== 16'hFFFE || lt_s0[1] || lt_s1[1]) begin
            errors++; $display("FAIL load_ch1 got %h %h lt %b %b want FFFE lt 0",
                               count_s0[31:16], count_s1[31:16], lt_s0[1], lt_s1[1]);
        end
        for (int j = 0; j < 3; j++) begin
            up = 4'b0010;
            cyc();
            n0 += int'(lt_s0[1]);
            n1 += int'(lt_s1[1]);
            checks++;
            if (count_s0[31:16] !== e0[j] || lt_s0[1] !== l0[j]) begin
                errors++; $display("FAIL wrap_step %0d got %h lt %b want %h lt %b", j, count_s0[31:16], lt_s0[1], e0[j], l0[j]);
            end
            checks++;
            if (count_s1[31:16] !== e1[j] || lt_s1[1] !== l1[j]) begin
                errors++; $display("FAIL sat_step %0d got %h lt %b want %h lt %b", j, count_s1[31:16], lt_s1[1], e1[j], l1[j]);
            end
        end
        up = '0;
        cyc();
        n0 += int'(lt_s0[1]);
        n1 += int'(lt_s1[1]);
        checks++;
        if (n0 != 1 || n1 != 2) begin
            errors++; $display("FAIL limit_pulse_count got %0d %0d want 1 2", n0, n1);
        end
    endtask

    task automatic test_updown_disable();
        load_value = 16'd100;
        ch_load = 4'b0100;
        cyc();
        ch_load = '0;
        up = 4'b0100; down = 4'b0100;
        cyc();
        checks++;
        if (count_s0[47:32] !== 16'd101 || count_s1[47:32] !== 16'd101) begin
            errors++; $display("FAIL up_down_same got %0d %0d want 101", count_s0[47:32], count_s1[47:32]);
        end
        ch_disable = 4'b0100; down = '0;
        cyc();
        checks++;
        if (count_s0[47:32] !== 16'd101 || count_s1[47:32] !== 16'd101) begin
            errors++; $display("FAIL disabled_up got %0d %0d want 101", count_s0[47:32], count_s1[47:32]);
        end
        up = '0; down = 4'b0100;
        cyc();
        checks++;
        if (count_s0[47:32] !== 16'd101 || count_s1[47:32] !== 16'd101) begin
            errors++; $display("FAIL disabled_down got %0d %0d want 101", count_s0[47:32], count_s1[47:32]);
        end
        down = '0; ch_disable = '0;
    endtask

    task automatic test_match();
        logic e_mt [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [1:0] op [7] = '{2'd1, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0};
        int n0 = 0, n1 = 0;
        compare[63:48] = 16'd5;
        load_value = 16'd4;
        ch_load = 4'b1000;
        cyc();
        ch_load = '0;
        n0 += int'(mt_s0[3]);
        n1 += int'(mt_s1[3]);
        for (int j = 0; j < 7; j++) begin
            up   = (op[j] == 2'd1) ? 4'b1000 : 4'b0000;
            down = (op[j] == 2'd2) ? 4'b1000 : 4'b0000;
            cyc();
            n0 += int'(mt_s0[3]);
            n1 += int'(mt_s1[3]);
            checks++;
            if (mt_s0[3] !== e_mt[j] || mt_s1[3] !== e_mt[j]) begin
                errors++; $display("FAIL match_step %0d got %b %b want %b", j, mt_s0[3], mt_s1[3], e_mt[j]);
            end
        end
        up = '0; down = '0;
        checks++;
        if (n0 != 2 || n1 != 2) begin
            errors++; $display("FAIL match_pulse_count got %0d %0d want 2", n0, n1);
        end
    endtask

    task automatic test_capture();
        int guard = 0;
        ch_reset = 4'b0001;
        cyc();
        ch_reset = '0;
        while (m_cnt[0][0] != 7 && guard < 100) begin
            cyc();
            guard++;
        end
        checks++;
        if (guard >= 100) begin
            errors++; $display("FAIL capture_wait got timeout want count 7");
        end
        capture = 1'b1;
        cyc();
        capture = 1'b0;
        checks++;
        if (snap_s0[15:0] !== 16'd7 || snap_s1[15:0] !== 16'd7) begin
            errors++; $display("FAIL capture_value got %0d %0d want 7", snap_s0[15:0], snap_s1[15:0]);
        end
        repeat (8) cyc();
        checks++;
        if (snap_s0[15:0] !== 16'd7 || count_s0 !== exp_cnt(0) || m_cnt[0][0] <= 7) begin
            errors++; $display("FAIL capture_hold snap %0d count %h want snap 7 count %h", snap_s0[15:0], count_s0, exp_cnt(0));
        end
    endtask

    task automatic test_random();
        logic [15:0] pool [5] = '{16'h0000, 16'h0001, 16'hFFFE, 16'hFFFF, 16'h0003};
        for (int c = 0; c < 600; c++) begin
            ch_reset   = '0;
            ch_load    = '0;
            for (int i = 0; i < N; i++) begin
                ch_reset[i]   = ($urandom_range(31) == 0);
                ch_load[i]    = ($urandom_range(15) == 0);
                ch_disable[i] = ($urandom_range(3) == 0);
                ch_auto[i]    = $urandom_range(1);
                up[i]         = ($urandom_range(2) == 0);
                down[i]       = ($urandom_range(2) == 0);
                if ($urandom_range(15) == 0) compare[i*WIDTH +: WIDTH] = 16'($urandom_range(4)) - 16'd1;
            end
            load_value = pool[$urandom_range(4)];
            capture    = ($urandom_range(7) == 0);
            if ($urandom_range(63) == 0) div_reload = DIV_W'($urandom_range(4));
            cyc();
            checks++;
            if (count_s0 !== exp_cnt(0) || count_s1 !== exp_cnt(1)) begin
                errors++; $display("FAIL rand_count c%0d got %h %h want %h %h", c, count_s0, count_s1, exp_cnt(0), exp_cnt(1));
            end
            checks++;
            if (snap_s0 !== exp_snap(0) || snap_s1 !== exp_snap(1)) begin
                errors++; $display("FAIL rand_snapshot c%0d got %h %h want %h %h", c, snap_s0, snap_s1, exp_snap(0), exp_snap(1));
            end
            checks++;
            if (mt_s0 !== exp_mt(0) || mt_s1 !== exp_mt(1)) begin
                errors++; $display("FAIL rand_match c%0d got %b %b want %b %b", c, mt_s0, mt_s1, exp_mt(0), exp_mt(1));
            end
            checks++;
            if (lt_s0 !== exp_lt(0) || lt_s1 !== exp_lt(1)) begin
                errors++; $display("FAIL rand_limit c%0d got %b %b want %b %b", c, lt_s0, lt_s1, exp_lt(0), exp_lt(1));
            end
            checks++;
            if (tick_s0 !== m_tick || tick_s1 !== m_tick) begin
                errors++; $display("FAIL rand_tick c%0d got %b %b want %b", c, tick_s0, tick_s1, m_tick);
            end
        end
        ch_reset = '0; ch_load = '0; ch_disable = '0; up = '0; down = '0; capture = 1'b0;
    endtask

    task automatic test_reset_mid();
        div_reload = DIV_W'(2);
        ch_auto = 4'b1111;
        repeat (3) cyc();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        checks++;
        if ({count_s0, count_s1, snap_s0, snap_s1} !== '0) begin
            errors++; $display("FAIL midreset_values got %h %h %h %h want 0", count_s0, count_s1, snap_s0, snap_s1);
        end
        checks++;
        if ({tick_s0, tick_s1, mt_s0, mt_s1, lt_s0, lt_s1} !== '0) begin
            errors++; $display("FAIL midreset_pulses got %b %b %b %b %b %b want 0", tick_s0, tick_s1, mt_s0, mt_s1, lt_s0, lt_s1);
        end
        repeat (2) cyc();
        reset = 1'b0;
        cyc();
        checks++;
        if (tick_s0 !== 1'b1 || tick_s1 !== 1'b1) begin
            errors++; $display("FAIL midreset_first_tick got %b %b want 1", tick_s0, tick_s1);
        end
        cyc();
        checks++;
        if (tick_s0 !== 1'b0 || count_s0 !== exp_cnt(0) || count_s1 !== exp_cnt(1)) begin
            errors++; $display("FAIL midreset_restart tick %b count %h want tick 0 count %h", tick_s0, count_s0, exp_cnt(0));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        test_reset();
        test_prescaler();
        test_wrap_saturate();
        test_updown_disable();
        test_match();
        test_capture();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
